isp_demosaic_ctrl: RTL

Frame sequencer for the 3x3 bilinear demosaic datapath. It accepts the RAW pixel stream with a ready/valid handshake and drives the two cascaded line-buffer FIFOs and the window-shift strobe. It also inserts the virtual tail column and virtual bottom row needed to complete edge windows, supplies the Bayer phase per centre pixel, and emits aligned output framing (valid/sof/eol).
It sits between the sensor capture front-end and the demosaic datapath. All datapath arithmetic stays in the datapath.

---
 rtl/isp_pkg.sv | 24 ++
 rtl/isp_delay_line.sv | 26 ++
 rtl/isp_demosaic_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/isp_pkg.sv
// Shared ISP definitions: sequencer state encoding, Bayer phase codes and the
// centre-pixel phase helper used by the demosaic controller.
package isp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LINE  = 3'd1,
    ST_TAIL  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] BAYER_RGGB = 2'b00;
  localparam logic [1:0] BAYER_GRBG = 2'b01;
  localparam logic [1:0] BAYER_GBRG = 2'b10;
  localparam logic [1:0] BAYER_BGGR = 2'b11;

  // The centre sits one row and one column behind the strobe, so its parity is inverted.
  function automatic logic [1:0] centre_phase(input logic row_lsb, input logic col_lsb,
                                              input logic [1:0] bayer);
    return {~row_lsb, ~col_lsb} ^ bayer;
  endfunction

endpackage

// File: rtl/isp_delay_line.sv
// Fixed-depth register delay line with asynchronous clear, used to align
// control qualifiers with datapath latency.
module isp_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_p [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_p[i] <= '0;
    end else begin
      pipe_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe_p[i] <= pipe_p[i-1];
    end
  end

  assign dout = pipe_p[DEPTH-1];

endmodule

// File: rtl/isp_demosaic_ctrl.sv
// Frame sequencer for the 3x3 bilinear demosaic: accepts RAW pixels, inserts the
// virtual tail column and bottom row, drives line buffers and aligned output framing.
module isp_demosaic_ctrl
  import isp_pkg::*;
#(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080,
  parameter int LAT    = 3,
  parameter int CW     = $clog2(WIDTH + 1),
  parameter int RW     = $clog2(HEIGHT + 1)
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       cfg_enable,
  input  logic [1:0] cfg_bayer,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       in_ready,
  output logic       win_shift,
  output logic       virt,
  output logic       fifo1_we,
  output logic       fifo1_re,
  output logic       fifo2_we,
  output logic       fifo2_re,
  output logic [1:0] pix_fmt,
  output logic       out_valid,
  output logic       out_sof,
  output logic       out_eol,
  output logic       busy,
  output logic       frame_done,
  output logic       err_sof
);

  localparam logic [CW-1:0] COL_ONE   = CW'(1);
  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] COL_TAIL  = CW'(WIDTH);
  localparam logic [RW-1:0] ROW_ONE   = RW'(1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FLUSH = RW'(HEIGHT);

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0]    bayer;
  logic          armed;

  logic          accept;
  logic          sof_start;
  logic          strobe;
  logic          fifo_slot;
  logic [CW-1:0] s_col;
  logic [RW-1:0] s_row;
  logic [1:0]    s_bayer;
  logic          centre_vld;
  logic          centre_sof;
  logic          centre_eol;
  logic [2:0]    align_out;

  // armed keeps in_ready low while rst_n is held, without using reset as data.
  always_comb begin
    in_ready = 1'b0;
    virt     = 1'b0;
    case (state)
      ST_IDLE:           in_ready = cfg_enable & armed;
      ST_LINE:           in_ready = 1'b1;
      ST_TAIL, ST_FLUSH: virt     = 1'b1;
      default: ;
    endcase
    accept    = in_valid & in_ready;
    sof_start = (state == ST_IDLE) & accept & in_sof;
    strobe    = virt | ((state == ST_LINE) & accept) | sof_start;
    // The first pixel of a frame is processed as (0,0) before the counters load.
    s_col     = (state == ST_IDLE) ? '0 : col;
    s_row     = (state == ST_IDLE) ? '0 : row;
    s_bayer   = (state == ST_IDLE) ? cfg_bayer : bayer;
  end

  assign win_shift  = strobe;
  assign fifo_slot  = strobe & (s_col != COL_TAIL);
  assign fifo1_we   = fifo_slot & ~virt;
  assign fifo1_re   = fifo_slot & (s_row != '0);
  assign fifo2_we   = fifo1_re & (s_row != ROW_FLUSH);
  assign fifo2_re   = fifo1_re & (s_row != ROW_ONE);

  assign centre_vld = strobe & (s_row != '0) & (s_col != '0);
  assign centre_sof = centre_vld & (s_row == ROW_ONE) & (s_col == COL_ONE);
  assign centre_eol = centre_vld & (s_col == COL_TAIL);

  assign busy       = sof_start | (state == ST_LINE) | (state == ST_TAIL) | (state == ST_FLUSH);
  assign frame_done = (state == ST_DONE);
  assign err_sof    = (state == ST_LINE) & accept & in_sof;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      col     <= '0;
      row     <= '0;
      bayer   <= '0;
      armed   <= 1'b0;
      pix_fmt <= '0;
    end else begin
      armed <= 1'b1;
      if (strobe) pix_fmt <= centre_phase(s_row[0], s_col[0], s_bayer);
      case (state)
        ST_IDLE: begin
          if (sof_start) begin
            bayer <= cfg_bayer;
            row   <= '0;
            col   <= COL_ONE;
            state <= (WIDTH == 1) ? ST_TAIL : ST_LINE;
          end
        end
        ST_LINE: begin
          if (accept) begin
            col <= col + COL_ONE;
            if (col == COL_LAST) state <= ST_TAIL;
          end
        end
        ST_TAIL: begin
          col   <= '0;
          row   <= row + ROW_ONE;
          state <= (row == ROW_LAST) ? ST_FLUSH : ST_LINE;
        end
        ST_FLUSH: begin
          if (col == COL_TAIL) begin
            col   <= '0;
            row   <= '0;
            state <= ST_DONE;
          end else begin
            col <= col + COL_ONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage boundary: strobe qualifiers delayed to match datapath RGB latency.
  isp_delay_line #(
    .WIDTH(3),
    .DEPTH(LAT)
  ) u_align (
    .clk  (pclk),
    .rst_n(rst_n),
    .din  ({centre_vld, centre_sof, centre_eol}),
    .dout (align_out)
  );

  assign out_valid = align_out[2];
  assign out_sof   = align_out[1];
  assign out_eol   = align_out[0];

endmodule
